// File: rtl/vga_mem_sched.sv
// vga_mem_sched: arbitrates display line fetches and writer bursts onto one memory command port
module vga_mem_sched #(
  parameter int H_ACT = 800,
  parameter int V_ACT = 600,
  parameter int BURST = 16,
  parameter int AW    = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          line_req,
  input  logic          wr_req,
  input  logic          mem_cmd_ready,
  input  logic          mem_burst_done,
  output logic          mem_cmd_valid,
  output logic          mem_cmd_wr,
  output logic [AW-1:0] mem_cmd_addr,
  output logic          wr_grant,
  output logic          rd_busy,
  output logic          line_overrun
);
  localparam int NB = H_ACT / BURST;
  localparam int CW = $clog2(NB + 1);
  localparam int LW = V_ACT > 1 ? $clog2(V_ACT) : 1;
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, WR_WAIT} state_t;
  state_t state, state_nx;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [CW-1:0] rd_left;
  logic [LW-1:0] line;
  logic          frame_pend;
  logic          rd_done, wr_done, rd_last, wr_wrap;
  logic [AW:0]   wr_sum;
  assign rd_done = state == RD_WAIT && mem_burst_done;
  assign wr_done = state == WR_WAIT && mem_burst_done;
  assign rd_last = rd_done && rd_left == CW'(1);
  assign wr_sum  = {1'b0, wr_addr} + (AW+1)'(BURST);
  assign wr_wrap = wr_sum >= (AW+1)'(H_ACT * V_ACT);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // arbitration and command decode; a line_req seen in IDLE already wins over a waiting writer
  always_comb begin
    state_nx      = state;
    mem_cmd_valid = 1'b0;
    mem_cmd_wr    = 1'b0;
    mem_cmd_addr  = '0;
    case (state)
      IDLE:    state_nx = (rd_busy || line_req) ? RD_CMD : wr_req ? WR_CMD : IDLE;
      RD_CMD: begin
        state_nx      = mem_cmd_ready ? RD_WAIT : RD_CMD;
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = rd_addr;
      end
      RD_WAIT: state_nx = mem_burst_done ? IDLE : RD_WAIT;
      WR_CMD: begin
        state_nx      = mem_cmd_ready ? WR_WAIT : WR_CMD;
        mem_cmd_valid = 1'b1;
        mem_cmd_wr    = 1'b1;
        mem_cmd_addr  = wr_addr;
      end
      WR_WAIT: state_nx = mem_burst_done ? IDLE : WR_WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // grant is registered, so it appears in the cycle right after the write is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_grant <= 1'b0;
    else wr_grant <= state == WR_CMD && mem_cmd_ready;
  // line fetch bookkeeping: busy flag, overrun, bursts left in the line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_busy      <= 1'b0;
      line_overrun <= 1'b0;
      rd_left      <= '0;
    end else begin
      if (line_req && rd_busy) line_overrun <= 1'b1;
      if (line_req && !rd_busy) begin
        rd_busy <= 1'b1;
        rd_left <= CW'(NB);
      end
      if (rd_done) rd_left <= rd_left - CW'(1);
      if (rd_last) rd_busy <= 1'b0;
    end
  // read pointer walks line*H_ACT + burst*BURST; frame clear waits until no line is in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_addr    <= '0;
      line       <= '0;
      frame_pend <= 1'b0;
    end else begin
      if (frame_start && !rd_busy) begin
        rd_addr    <= '0;
        line       <= '0;
        frame_pend <= 1'b0;
      end else if (frame_start) frame_pend <= 1'b1;
      if (rd_done) rd_addr <= rd_addr + AW'(BURST);
      if (rd_last) begin
        frame_pend <= 1'b0;
        if (frame_pend || frame_start || line == LW'(V_ACT - 1)) begin
          rd_addr <= '0;
          line    <= '0;
        end else line <= line + LW'(1);
      end
    end
  // write pointer advances per completed burst and wraps at the end of the frame buffer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wr_addr <= '0;
    else if (wr_done) wr_addr <= wr_wrap ? '0 : wr_sum[AW-1:0];
endmodule

// File: tb/tb_vga_mem_sched.sv
// tb_vga_mem_sched: table-driven cycle vectors on a small instance plus directed sequences on the default one
module tb_vga_mem_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic d_fs = 0, d_lr = 0, d_wq = 0, d_rdy = 1, d_dn = 0;
  logic d_v, d_w, d_g, d_b, d_o;
  logic [19:0] d_a;
  logic s_fs = 0, s_lr = 0, s_wq = 0, s_rdy = 0, s_dn = 0;
  logic s_v, s_w, s_g, s_b, s_o;
  logic [5:0] s_a;
  int tests = 0, fails = 0;
  vga_mem_sched dut (
    .clk(clk), .rst_n(rst_n), .frame_start(d_fs), .line_req(d_lr), .wr_req(d_wq),
    .mem_cmd_ready(d_rdy), .mem_burst_done(d_dn), .mem_cmd_valid(d_v), .mem_cmd_wr(d_w),
    .mem_cmd_addr(d_a), .wr_grant(d_g), .rd_busy(d_b), .line_overrun(d_o));
  vga_mem_sched #(.H_ACT(32), .V_ACT(2), .BURST(16), .AW(6)) sdut (
    .clk(clk), .rst_n(rst_n), .frame_start(s_fs), .line_req(s_lr), .wr_req(s_wq),
    .mem_cmd_ready(s_rdy), .mem_burst_done(s_dn), .mem_cmd_valid(s_v), .mem_cmd_wr(s_w),
    .mem_cmd_addr(s_a), .wr_grant(s_g), .rd_busy(s_b), .line_overrun(s_o));
  // memory model for the default instance: done pulse sampled 4 cycles after each accept
  logic acc = 0;
  int cnt = 0;
  always @(posedge clk) acc <= d_v && d_rdy;
  always @(negedge clk) begin
    d_dn = 1'b0;
    if (cnt != 0) begin
      cnt = cnt - 1;
      d_dn = (cnt == 0);
    end
    if (acc) cnt = 3;
  end
  typedef struct { logic w; logic [19:0] a; } cmd_t;
  cmd_t log_q[$];
  int grants = 0;
  always @(posedge clk) begin
    if (d_v && d_rdy) log_q.push_back('{d_w, d_a});
    if (d_g) grants++;
  end
  typedef struct { logic [4:0] in; logic v, w; logic [5:0] a; logic g, b, o; } vec_t;
  vec_t tab[$];
  function automatic void add(logic [4:0] in, logic ev, logic ew, int ea, logic eg, logic eb, logic eo);
    tab.push_back('{in, ev, ew, 6'(ea), eg, eb, eo});
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_cmds(input int n, input string name);
    int k = 0;
    while (log_q.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(log_q.size() >= n), 1);
  endtask
  task automatic wait_idle(input string name);
    int k = 0;
    while (d_b && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(d_b), 0);
  endtask
  task automatic chk_cmd(input string name, input int i, input logic ew, input int ea);
    if (i < log_q.size()) chk(name, {log_q[i].w, log_q[i].a}, {ew, 20'(ea)});
    else chk(name, 64'(log_q.size()), 64'(i + 1));
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    // small instance: H_ACT=32 V_ACT=2 BURST=16; inputs {fs,lr,wq,rdy,dn} -> {valid,wr,addr,grant,busy,overrun}
    add(5'b00110, 1, 1,  0, 0, 0, 0); add(5'b00110, 0, 0, 0, 1, 0, 0); add(5'b00111, 0, 0, 0, 0, 0, 0);
    add(5'b00110, 1, 1, 16, 0, 0, 0); add(5'b00110, 0, 0, 0, 1, 0, 0); add(5'b00111, 0, 0, 0, 0, 0, 0);
    add(5'b00110, 1, 1, 32, 0, 0, 0); add(5'b00110, 0, 0, 0, 1, 0, 0); add(5'b00111, 0, 0, 0, 0, 0, 0);
    add(5'b00110, 1, 1, 48, 0, 0, 0); add(5'b00110, 0, 0, 0, 1, 0, 0); add(5'b00111, 0, 0, 0, 0, 0, 0);
    add(5'b00110, 1, 1,  0, 0, 0, 0); add(5'b00010, 0, 0, 0, 1, 0, 0); add(5'b00011, 0, 0, 0, 0, 0, 0);
    add(5'b01011, 1, 0,  0, 0, 1, 0); add(5'b00010, 0, 0, 0, 0, 1, 0); add(5'b00011, 0, 0, 0, 0, 1, 0);
    add(5'b10010, 1, 0, 16, 0, 1, 0); add(5'b01010, 0, 0, 0, 0, 1, 1); add(5'b00011, 0, 0, 0, 0, 0, 1);
    add(5'b01010, 1, 0,  0, 0, 1, 1); add(5'b00010, 0, 0, 0, 0, 1, 1); add(5'b00011, 0, 0, 0, 0, 1, 1);
    add(5'b00010, 1, 0, 16, 0, 1, 1); add(5'b00010, 0, 0, 0, 0, 1, 1); add(5'b00011, 0, 0, 0, 0, 0, 1);
    add(5'b01010, 1, 0, 32, 0, 1, 1); add(5'b00010, 0, 0, 0, 0, 1, 1); add(5'b00011, 0, 0, 0, 0, 1, 1);
    add(5'b00010, 1, 0, 48, 0, 1, 1); add(5'b00010, 0, 0, 0, 0, 1, 1); add(5'b00011, 0, 0, 0, 0, 0, 1);
    add(5'b01000, 1, 0,  0, 0, 1, 1); add(5'b00001, 1, 0, 0, 0, 1, 1); add(5'b00010, 0, 0, 0, 0, 1, 1);
    add(5'b00011, 0, 0,  0, 0, 1, 1); add(5'b00010, 1, 0, 16, 0, 1, 1); add(5'b00010, 0, 0, 0, 0, 1, 1);
    add(5'b00011, 0, 0,  0, 0, 0, 1); add(5'b11010, 1, 0, 0, 0, 1, 1);
    repeat (3) @(negedge clk);
    chk("reset_default", {d_v, d_w, d_a, d_g, d_b, d_o}, 0);
    chk("reset_small", {s_v, s_w, s_a, s_g, s_b, s_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (tab[i]) begin
      {s_fs, s_lr, s_wq, s_rdy, s_dn} = tab[i].in;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {s_v, s_w, s_a, s_g, s_b, s_o},
          {tab[i].v, tab[i].w, tab[i].a, tab[i].g, tab[i].b, tab[i].o});
      @(negedge clk);
    end
    {s_fs, s_lr, s_wq, s_rdy, s_dn} = 5'b0;
    // full line fetch after frame_start
    d_fs = 1; @(negedge clk); d_fs = 0; d_lr = 1; @(negedge clk); d_lr = 0;
    wait_cmds(50, "line0_count");
    wait_idle("line0_busy_fall");
    chk("line0_no_extra", 64'(log_q.size()), 50);
    for (int i = 0; i < 50; i++) chk_cmd($sformatf("line0_cmd%0d", i), i, 0, i * 16);
    // read priority over a pending writer
    log_q.delete();
    d_wq = 1; d_lr = 1; @(negedge clk); d_lr = 0;
    wait_cmds(50, "prio_reads");
    chk("prio_no_grant", 64'(grants), 0);
    chk_cmd("prio_first_read", 0, 0, 800);
    chk_cmd("prio_last_read", 49, 0, 800 + 49 * 16);
    wait_cmds(51, "prio_write");
    d_wq = 0;
    chk_cmd("prio_write_cmd", 50, 1, 0);
    repeat (3) @(negedge clk);
    chk("prio_grant", 64'(grants), 1);
    repeat (8) @(negedge clk);
    // line_req during a write burst waits for that burst
    log_q.delete();
    d_wq = 1;
    wait_cmds(1, "nopre_write");
    d_wq = 0;
    chk_cmd("nopre_write_cmd", 0, 1, 16);
    d_lr = 1; @(negedge clk); d_lr = 0;
    chk("nopre_hold", {d_v, d_b}, 2'b01);
    wait_cmds(2, "nopre_read");
    chk_cmd("nopre_read_cmd", 1, 0, 1600);
    wait_idle("nopre_line_done");
    d_wq = 1;
    wait_cmds(52, "nopre_next_write");
    d_wq = 0;
    chk_cmd("nopre_wr_advance", 51, 1, 32);
    repeat (8) @(negedge clk);
    // backpressure: command held for 7 cycles, accepted on the 8th
    log_q.delete();
    d_rdy = 0; d_wq = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {d_v, d_w, d_a}, {1'b1, 1'b1, 20'd48});
    end
    d_rdy = 1; d_wq = 0;
    @(negedge clk);
    chk_cmd("bp_accept", 0, 1, 48);
    chk("bp_grant", {d_g, d_v}, 2'b10);
    @(negedge clk);
    chk("bp_grant_pulse", 64'(d_g), 0);
    repeat (8) @(negedge clk);
    // overrun, then reset in RD_WAIT
    log_q.delete();
    d_lr = 1; @(negedge clk); d_lr = 0;
    chk("ovr_clear", 64'(d_o), 0);
    d_lr = 1; @(negedge clk); d_lr = 0;
    chk("ovr_set", 64'(d_o), 1);
    wait_cmds(1, "rst_wait_accept");
    chk("ovr_sticky", {d_o, d_v}, 2'b10);
    #2 rst_n = 0;
    #1 chk("rst_async", {d_v, d_w, d_a, d_g, d_b, d_o}, 0);
    @(negedge clk);
    rst_n = 1;
    log_q.delete();
    repeat (10) @(negedge clk);
    chk("rst_no_cmd", 64'(log_q.size()), 0);
    d_lr = 1; @(negedge clk); d_lr = 0;
    wait_cmds(1, "rst_refetch");
    chk_cmd("rst_refetch_addr", 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_mem_sched.md
VGA_MEM_SCHED -- requirements
Module: vga_mem_sched

Interface
REQ-001 Parameter H_ACT, default 800: active pixels per line.
REQ-002 Parameter V_ACT, default 600: active lines per frame.
REQ-003 Parameter BURST, default 16: pixels per memory burst; H_ACT SHALL be an integer multiple of BURST.
REQ-004 Parameter AW, default 20: memory pixel-address width, with 2^AW >= H_ACT*V_ACT.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 frame_start  input  1  one-cycle pulse at the start of display vertical sync.
REQ-008 line_req  input  1  one-cycle pulse: the display line buffer needs the next line.
REQ-009 wr_req  input  1  level: the image-processing writer holds at least one BURST of pixels.
REQ-010 mem_cmd_ready  input  1  memory accepts the command this cycle.
REQ-011 mem_burst_done  input  1  one-cycle pulse: the accepted burst has completed.
REQ-012 mem_cmd_valid  output  1  command is presented.
REQ-013 mem_cmd_wr  output  1  1 = write burst, 0 = read burst.
REQ-014 mem_cmd_addr  output  AW  start pixel address of the burst.
REQ-015 wr_grant  output  1  one-cycle pulse when a write command is accepted.
REQ-016 rd_busy  output  1  a display line fetch is in progress.
REQ-017 line_overrun  output  1  sticky flag: line_req arrived while rd_busy was 1.

Function
REQ-018 The FSM SHALL use states IDLE, RD_CMD, RD_WAIT, WR_CMD and WR_WAIT.
REQ-019 On line_req in any state, if rd_busy=0 the block SHALL set rd_busy=1 and load rd_left=H_ACT/BURST; if rd_busy=1 it SHALL set line_overrun=1 and ignore the request.
REQ-020 IDLE arbitration:
- rd_busy=1 -> RD_CMD (read has priority).
- else wr_req=1 -> WR_CMD.
- else stay in IDLE.
REQ-021 In RD_CMD and WR_CMD, mem_cmd_valid SHALL be 1; mem_cmd_wr, mem_cmd_addr and valid SHALL stay stable until mem_cmd_ready=1.
REQ-022 On the accepting cycle the FSM SHALL go from RD_CMD to RD_WAIT, or from WR_CMD to WR_WAIT; mem_cmd_valid SHALL be 0 in both WAIT states.
REQ-023 A burst in progress SHALL never be pre-empted; a read request is serviced only after the current write burst completes.
REQ-024 RD_WAIT on mem_burst_done:
- rd_addr += BURST and rd_left -= 1.
- If rd_left reaches 0: rd_busy=0, line counter += 1.
- Return to IDLE.
REQ-025 WR_WAIT on mem_burst_done: wr_addr += BURST; when wr_addr+BURST would reach H_ACT*V_ACT, wr_addr SHALL wrap to 0; return to IDLE.
REQ-026 The read address SHALL be line*H_ACT + burst_index*BURST.
REQ-027 The line counter SHALL wrap from V_ACT-1 to 0 and SHALL also clear on frame_start.
REQ-028 frame_start SHALL clear rd_addr and the line counter next cycle, but only when rd_busy=0; if rd_busy=1 the clear SHALL be deferred until the line completes.
REQ-029 If line_req and frame_start coincide with rd_busy=0, the frame clear SHALL apply first and the fetch SHALL start at address 0.
REQ-030 wr_grant SHALL pulse on the WR_CMD accepting cycle only.
REQ-031 mem_burst_done in IDLE, RD_CMD or WR_CMD SHALL be ignored.
REQ-032 line_overrun SHALL clear only on reset.
REQ-033 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-034 rst_n=0 SHALL asynchronously force:
- state IDLE;
- mem_cmd_valid=0, mem_cmd_wr=0, mem_cmd_addr=0;
- wr_grant=0, rd_busy=0, line_overrun=0;
- rd_addr=0, wr_addr=0, line counter 0, rd_left=0.
REQ-035 Reset asserted mid-burst SHALL abandon the burst; after release no command SHALL issue until a new request arrives.

Verification
REQ-036 Line fetch: frame_start, then line_req, with mem_cmd_ready=1 and done 4 cycles after each accept -> 50 read commands at addresses 0,16,...,784; rd_busy falls after the 50th done.
REQ-037 Priority: wr_req=1 and line_req in the same cycle from IDLE -> first command is a read; write issues only after all 50 reads; no wr_grant until then.
REQ-038 No pre-emption: line_req while in WR_WAIT -> write completes first, then the read command issues, then wr_addr advances by 16.
REQ-039 Backpressure: mem_cmd_ready=0 for 7 cycles -> valid, addr and wr held constant; command accepted on cycle 8.
REQ-040 Wrap and overrun:
- Force wr_addr=479984 -> next write at 479984, following write at 0.
- A second line_req while rd_busy=1 -> line_overrun=1 and remains set.
REQ-041 Reset mid-RD_WAIT -> all outputs 0 next cycle; the next line_req fetch starts at address 0.
